imem_loader: RTL and testbench

Boot-time instruction loader that sits directly upstream of the single-cycle MIPS core and its instruction memory. It receives a length-prefixed, checksummed program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words into instruction memory through a dedicated write port, holding the core in reset until a verified image is in place.

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream ingress, instruction-memory write port and core control for imem_loader.
// Signals only; no logic or latency.
// ByteValid is held by the source until a cycle where ByteReady is also high.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              ByteValid;
    logic [7:0]        ByteData;
    logic              ByteReady;
    logic              Start;
    logic              IMWrite;
    logic [ADDR_W-1:0] IMWAddr;
    logic [31:0]       IMWData;
    logic              CoreRST;
    logic              Done;
    logic              Error;

    // Host side: byte source, reload request, and observer of memory/core control.
    modport master (
        output ByteValid, ByteData, Start,
        input  ByteReady, IMWrite, IMWAddr, IMWData, CoreRST, Done, Error
    );

    // Loader side.
    modport slave (
        input  ByteValid, ByteData, Start,
        output ByteReady, IMWrite, IMWAddr, IMWData, CoreRST, Done, Error
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed, XOR-checksummed byte stream -> big-endian words in instruction memory.
// Latency: IMWrite one cycle after a word's 4th byte; CoreRST/Done/Error on the checksum-accept edge.
// Backpressure: ByteReady is a pure state decode, high only in LEN_HI, LEN_LO, DATA and CSUM.
module imem_loader #(
    parameter int ADDR_W = 5
) (
    input  logic          CLK,
    input  logic          RST,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t            state;
    state_t            stateNext;
    logic              byteReady;
    logic              accept;
    logic [15:0]       len;
    logic [15:0]       fullLen;
    logic              lenBad;
    logic [ADDR_W:0]   wordIdx;
    logic [7:0]        csum;
    logic [23:0]       shiftReg;
    logic [1:0]        byteCnt;
    logic              lastByte;

    assign accept  = bus.ByteValid & byteReady;
    assign fullLen = {len[15:8], bus.ByteData};
    assign lenBad  = (fullLen == 16'd0) || ({1'b0, fullLen} > DEPTH);
    // Index is one bit wider than the address so Len = 2**ADDR_W terminates without wrapping.
    assign lastByte = (byteCnt == 2'd3) &&
                      ({{(15-ADDR_W){1'b0}}, wordIdx} == (len - 16'd1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= BOOT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            BOOT:    stateNext = LEN_HI;
            LEN_HI:  if (accept) stateNext = LEN_LO;
            LEN_LO:  if (accept) stateNext = lenBad ? ERR : DATA;
            DATA:    if (accept && lastByte) stateNext = CSUM;
            CSUM:    if (accept) stateNext = (bus.ByteData == csum) ? RUN : ERR;
            RUN:     if (bus.Start) stateNext = LEN_HI;
            ERR:     if (bus.Start) stateNext = LEN_HI;
            default: stateNext = BOOT;
        endcase
    end

    always_comb begin
        byteReady = 1'b0;
        case (state)
            LEN_HI, LEN_LO, DATA, CSUM: byteReady = 1'b1;
            default:                    byteReady = 1'b0;
        endcase
    end

    assign bus.ByteReady = byteReady;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            len         <= '0;
            wordIdx     <= '0;
            csum        <= '0;
            shiftReg    <= '0;
            byteCnt     <= '0;
            bus.IMWrite <= 1'b0;
            bus.IMWAddr <= '0;
            bus.IMWData <= '0;
        end else begin
            bus.IMWrite <= 1'b0;
            if (accept) begin
                case (state)
                    LEN_HI: len[15:8] <= bus.ByteData;
                    LEN_LO: begin
                        len[7:0] <= bus.ByteData;
                        wordIdx  <= '0;
                        csum     <= '0;
                        byteCnt  <= '0;
                    end
                    DATA: begin
                        csum <= csum ^ bus.ByteData;
                        if (byteCnt == 2'd3) begin
                            bus.IMWData <= {shiftReg, bus.ByteData};
                            bus.IMWAddr <= wordIdx[ADDR_W-1:0];
                            bus.IMWrite <= 1'b1;
                            wordIdx     <= wordIdx + 1'b1;
                            byteCnt     <= 2'd0;
                        end else begin
                            shiftReg <= {shiftReg[15:0], bus.ByteData};
                            byteCnt  <= byteCnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status follows the state being entered, so it flips on the same edge as the transition.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.CoreRST <= 1'b0;
            bus.Done    <= 1'b0;
            bus.Error   <= 1'b0;
        end else begin
            bus.CoreRST <= (stateNext == RUN);
            bus.Done    <= (stateNext == RUN);
            bus.Error   <= (stateNext == ERR);
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of directed loads, randomized loads against a byte-level model,
// and a mid-load reset sequence.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(5)) bus();

    imem_loader #(.ADDR_W(5)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int len;
        int pat;
        int maxGap;
        bit badCs;
        bit expDone;
        bit expErr;
        int expWrites;
    } vec_t;

    vec_t        vecs[7];
    logic [7:0]  dataBuf[128];
    logic [7:0]  img3[12];
    logic [4:0]  obsAddr[$];
    logic [31:0] obsData[$];
    bit          obsDbl[$];
    logic        prevW = 1'b0;

    always @(negedge clk) begin
        if (bus.IMWrite === 1'b1) begin
            obsAddr.push_back(bus.IMWAddr);
            obsData.push_back(bus.IMWData);
            obsDbl.push_back(prevW === 1'b1);
        end
        prevW <= bus.IMWrite;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, ".ByteReady"}, 32'(bus.ByteReady), 32'd0);
        chk({tag, ".IMWrite"},   32'(bus.IMWrite),   32'd0);
        chk({tag, ".IMWAddr"},   32'(bus.IMWAddr),   32'd0);
        chk({tag, ".IMWData"},   bus.IMWData,        32'd0);
        chk({tag, ".CoreRST"},   32'(bus.CoreRST),   32'd0);
        chk({tag, ".Done"},      32'(bus.Done),      32'd0);
        chk({tag, ".Error"},     32'(bus.Error),     32'd0);
    endtask

    task automatic sendByte(input logic [7:0] b, input int maxGap);
        int gap;
        int n;
        gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        if (gap > 0) begin
            bus.ByteValid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        bus.ByteValid = 1'b1;
        bus.ByteData  = b;
        n = 0;
        while (bus.ByteReady !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("byteAccept", 32'(bus.ByteReady), 32'd1);
        if (bus.ByteReady === 1'b1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic startPulse();
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        chk("start.Done",      32'(bus.Done),      32'd0);
        chk("start.Error",     32'(bus.Error),     32'd0);
        chk("start.CoreRST",   32'(bus.CoreRST),   32'd0);
        chk("start.ByteReady", 32'(bus.ByteReady), 32'd1);
    endtask

    // Model: Len must be 1..32; word k is bytes 4k..4k+3 big-endian at address k; RUN iff checksum matches.
    task automatic doLoad(input int len, input int maxGap, input bit badCs,
                          input bit expDone, input bit expErr, input int expWrites);
        int          base;
        int          nObs;
        bit          lenOk;
        logic [7:0]  cs;
        logic [31:0] w;
        base  = obsAddr.size();
        cs    = 8'h00;
        lenOk = (len >= 1) && (len <= 32);
        sendByte(8'(len >> 8), maxGap);
        sendByte(8'(len), maxGap);
        if (lenOk) begin
            for (int i = 0; i < 4 * len; i++) begin
                sendByte(dataBuf[i], maxGap);
                cs = cs ^ dataBuf[i];
            end
            sendByte(badCs ? (cs ^ 8'h01) : cs, maxGap);
        end
        bus.ByteValid = 1'b0;
        chk("end.Done",      32'(bus.Done),      32'(expDone));
        chk("end.Error",     32'(bus.Error),     32'(expErr));
        chk("end.CoreRST",   32'(bus.CoreRST),   32'(expDone));
        chk("end.ByteReady", 32'(bus.ByteReady), 32'd0);
        @(posedge clk);
        #1;
        if (!lenOk) begin
            bus.ByteValid = 1'b1;
            bus.ByteData  = 8'hA5;
            repeat (3) begin
                @(posedge clk);
                #1;
                chk("errNoAccept", 32'(bus.ByteReady), 32'd0);
            end
            bus.ByteValid = 1'b0;
        end
        nObs = obsAddr.size() - base;
        chk("nWrites", 32'(nObs), 32'(expWrites));
        for (int k = 0; k < expWrites && k < nObs; k++) begin
            w = {dataBuf[4*k], dataBuf[4*k+1], dataBuf[4*k+2], dataBuf[4*k+3]};
            chk("wrAddr",  32'(obsAddr[base+k]), 32'(k));
            chk("wrData",  obsData[base+k], w);
            chk("wrPulse", 32'(obsDbl[base+k]), 32'd0);
        end
    endtask

    task automatic fill(input int pat, input int len);
        logic [31:0] sw;
        sw = 32'h2008_0005;
        for (int i = 0; i < 128; i++) begin
            case (pat)
                0:       dataBuf[i] = (i < 4) ? sw[31 - 8*(i%4) -: 8] : 8'h00;
                1:       dataBuf[i] = ((i % 4) < 2) ? 8'h00 : 8'(i / 4);
                2:       dataBuf[i] = (i < 12) ? img3[i] : 8'h00;
                default: dataBuf[i] = 8'($urandom);
            endcase
        end
        if (len > 32) dataBuf[0] = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  len;
        int  gap;
        bit  b;
        bit  ok;
        vecs[0] = '{1,  0, 0, 1'b0, 1'b1, 1'b0, 1};
        vecs[1] = '{0,  3, 0, 1'b0, 1'b0, 1'b1, 0};
        vecs[2] = '{33, 3, 0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{1,  0, 0, 1'b1, 1'b0, 1'b1, 1};
        vecs[4] = '{32, 1, 0, 1'b0, 1'b1, 1'b0, 32};
        vecs[5] = '{3,  2, 0, 1'b0, 1'b1, 1'b0, 3};
        vecs[6] = '{3,  2, 5, 1'b0, 1'b1, 1'b0, 3};
        for (int i = 0; i < 12; i++) img3[i] = 8'($urandom);

        bus.ByteValid = 1'b0;
        bus.ByteData  = 8'h00;
        bus.Start     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("rst");
        rst = 1'b1;
        chk("boot.ByteReady", 32'(bus.ByteReady), 32'd0);
        @(posedge clk);
        #1;
        chk("lenhi.ByteReady", 32'(bus.ByteReady), 32'd1);
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        chk("startIgnored.ByteReady", 32'(bus.ByteReady), 32'd1);

        for (int i = 0; i < 7; i++) begin
            if (i > 0) startPulse();
            fill(vecs[i].pat, vecs[i].len);
            doLoad(vecs[i].len, vecs[i].maxGap, vecs[i].badCs,
                   vecs[i].expDone, vecs[i].expErr, vecs[i].expWrites);
        end

        for (int r = 0; r < 6; r++) begin
            startPulse();
            len = int'($urandom_range(34, 0));
            gap = int'($urandom_range(3, 0));
            b   = 1'($urandom_range(1, 0));
            ok  = (len >= 1) && (len <= 32);
            fill(3, len);
            doLoad(len, gap, b, ok && !b, !(ok && !b), ok ? len : 0);
        end

        startPulse();
        fill(3, 4);
        sendByte(8'h00, 0);
        sendByte(8'h04, 0);
        for (int i = 0; i < 6; i++) sendByte(dataBuf[i], 0);
        rst = 1'b0;
        #1;
        checkReset("midRst");
        bus.ByteValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        fill(3, 1);
        doLoad(1, 0, 1'b0, 1'b1, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
